cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the single-cycle CPU core's two memory ports: instruction fetch (instr_read/instr_addr → instr_out) and data load/store (data_read/data_addr/data_write/data_in → data_out).
- Holds one shared word-organised array serving both ports, with byte-strobed writes and registered read data.
- Flags out-of-range accesses with a sticky error flag.
- Sits at top level beside the core; replaces separate behavioural IM/DM models in simulation and synthesis.

Parameters:
- DEPTH_LOG2, 14, log2 of array depth in 32-bit words (default 16384 words = 64 KiB).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be DEPTH-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr_read  input  1  instruction read enable.
- instr_addr  input  32  instruction byte address.
- instr_out  output  32  registered instruction read data.
- data_read  input  1  data read enable.
- data_addr  input  32  data byte address.
- data_write  input  4  byte write strobes; bit i enables byte lane i.
- data_in  input  32  data write data; lane i = data_in[8i+7:8i].
- data_out  output  32  registered data read data.
- access_err  output  1  sticky out-of-range error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - instr_out = 0, data_out = 0, access_err = 0 immediately.
  - Array contents are not reset and are preserved across reset.
  - Release is synchronous to the next rising edge; no access completes on the edge where rst is low.
- Address decode:
  - offset = addr − BASE_ADDR (32-bit, wraps).
  - In range iff offset < 4·2^DEPTH_LOG2.
  - Word index = offset[DEPTH_LOG2+1:2]; addr[1:0] ignored (word-aligned access only).
- Read latency: 1 cycle.
  - If instr_read is high at edge N, instr_out holds word[instr_addr] after edge N.
  - Same rule for data_read/data_out.
  - Enable low: output holds its previous value.
- Write:
  - At an edge with data_write != 0 and address in range, only strobed lanes of the word are updated.
  - Unstrobed lanes are unchanged.
  - data_read is not required for a write.
- Data-port read and write in the same cycle: write-first. data_out = merged word (new strobed lanes, old unstrobed lanes).
- Instruction read same word as data write in the same cycle: instr_out also returns the merged word.
- Out of range:
  - A read returns 32'h0 on that port.
  - A write is dropped; no array lane changes, including via aliasing.
  - Either sets access_err to 1 at that edge.
  - access_err stays 1 until reset.
  - Enables low → no check, no error.
- Simultaneous instr and data reads to different words: both served in the same cycle; no arbitration, no stall.
- Mid-operation reset: any access sampled on a low-rst edge is discarded, including pending writes; outputs return to 0.
- X safety: enables and strobes sampled only when rst is high; address/data are don't-care when no enable or strobe is active.

Test Plan:
- Reset then write/read: drop rst, release; write 32'hDEADBEEF at data_addr 0x100 with strobe 4'hF; next cycle read 0x100 → data_out = 32'hDEADBEEF one edge later; access_err = 0.
- Byte strobes: preload 0x200 = 32'h11223344; write data_in 32'hAABBCCDD with strobe 4'b0101 → read returns 32'h11BB33DD.
- Write-first: with 0x300 = 32'h0, in the same cycle data_read=1 and write 32'h12345678 (strobe 4'b0011) to 0x300 → data_out = 32'h00005678.
- Cross-port bypass: data write 32'hCAFEF00D to 0x40 and instr_read of 0x40 in the same cycle → instr_out = 32'hCAFEF00D.
- Out of range (defaults): read data_addr 0x0001_0000 → data_out = 0 and access_err = 1. Write 32'hFFFFFFFF to 0x0001_0000 → word 0 unchanged. access_err stays 1 until rst goes low.
- Async reset mid-burst: during back-to-back reads with instr_out = 32'h00000013, pulse rst low between edges → instr_out and data_out = 0 immediately. A write strobed on the low-rst edge is not committed, and previously written 0x100 still reads 32'hDEADBEEF after release.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Shared word-organised memory serving the core's instruction-fetch and
//   data load/store ports. Reads are registered (1-cycle latency), writes are
//   byte-strobed, and out-of-range accesses set a sticky error flag.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset (clears outputs, not the array)
//   instr_read  instruction read enable
//   instr_addr  instruction byte address
//   instr_out   registered instruction read data
//   data_read   data read enable
//   data_addr   data byte address
//   data_write  byte write strobes, bit i -> lane i
//   data_in     data write data, lane i = data_in[8i+7:8i]
//   data_out    registered data read data
//   access_err  sticky out-of-range access flag
module cpu_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  input  logic        data_read,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        access_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  logic [31:0]           i_off, d_off;
  logic                  i_ok, d_ok;
  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic                  wr_en;
  logic [31:0]           i_word, d_word;

  // Offset wraps modulo 2^32; in range when no bit above the byte span is set.
  assign i_off = instr_addr - BASE_ADDR;
  assign d_off = data_addr - BASE_ADDR;
  assign i_ok  = (i_off >> (DEPTH_LOG2 + 2)) == '0;
  assign d_ok  = (d_off >> (DEPTH_LOG2 + 2)) == '0;
  assign i_idx = i_off[DEPTH_LOG2+1:2];
  assign d_idx = d_off[DEPTH_LOG2+1:2];
  assign wr_en = (data_write != '0) && d_ok;

  // Write-first view of the array: strobed lanes of the word being written
  // this cycle are forwarded to both read ports.
  always_comb begin
    d_word = mem[d_idx];
    i_word = mem[i_idx];
    for (int unsigned lane = 0; lane < 4; lane++) begin
      if (wr_en && data_write[lane]) begin
        d_word[8*lane +: 8] = data_in[8*lane +: 8];
        if (i_idx == d_idx)
          i_word[8*lane +: 8] = data_in[8*lane +: 8];
      end
    end
  end

  // The array is never cleared; sharing the async reset here only blocks a
  // write on any edge where rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (wr_en) begin
      for (int unsigned lane = 0; lane < 4; lane++) begin
        if (data_write[lane])
          mem[d_idx][8*lane +: 8] <= data_in[8*lane +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_out  <= '0;
      data_out   <= '0;
      access_err <= 1'b0;
    end else begin
      if (instr_read)
        instr_out <= i_ok ? i_word : '0;
      if (data_read)
        data_out <= d_ok ? d_word : '0;
      if ((instr_read && !i_ok) || ((data_read || data_write != '0) && !d_ok))
        access_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
//   Directed and randomized stimulus for cpu_mem_responder, checked against a
//   byte-addressed reference model of the memory.
module tb_cpu_mem_responder;

  localparam int unsigned DL   = 14;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SPAN = 32'(4 << DL);

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_addr;
  logic [31:0] instr_out;
  logic        data_read;
  logic [31:0] data_addr;
  logic [3:0]  data_write;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        access_err;

  cpu_mem_responder #(
    .DEPTH_LOG2(DL),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr_read(instr_read),
    .instr_addr(instr_addr),
    .instr_out (instr_out),
    .data_read (data_read),
    .data_addr (data_addr),
    .data_write(data_write),
    .data_in   (data_in),
    .data_out  (data_out),
    .access_err(access_err)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: bytes keyed by offset from BASE.
  logic [7:0]  mb [int unsigned];
  logic [31:0] exp_i   = '0;
  logic [31:0] exp_d   = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < SPAN;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    int unsigned key;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      key = ((a - BASE) & 32'hFFFF_FFFC) + 32'(b);
      if (mb.exists(key)) w[8*b +: 8] = mb[key];
    end
    return w;
  endfunction

  // One rising edge as the memory sees it: the write lands first, then both
  // ports read the updated contents.
  task automatic model_edge();
    int unsigned key;
    if (data_write != 4'b0) begin
      if (in_rng(data_addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (data_write[b]) begin
            key = ((data_addr - BASE) & 32'hFFFF_FFFC) + 32'(b);
            mb[key] = data_in[8*b +: 8];
          end
        end
      end else begin
        exp_err = 1'b1;
      end
    end
    if (data_read) begin
      if (in_rng(data_addr)) exp_d = rd_word(data_addr);
      else begin exp_d = '0; exp_err = 1'b1; end
    end
    if (instr_read) begin
      if (in_rng(instr_addr)) exp_i = rd_word(instr_addr);
      else begin exp_i = '0; exp_err = 1'b1; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check("instr_out", instr_out, exp_i);
    check("data_out", data_out, exp_d);
    check("access_err", {31'b0, access_err}, {31'b0, exp_err});
  endtask

  task automatic idle();
    instr_read = 1'b0;
    data_read  = 1'b0;
    data_write = 4'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    idle();
    data_addr  = a;
    data_in    = d;
    data_write = s;
    step();
    idle();
  endtask

  task automatic rd_data(input logic [31:0] a);
    idle();
    data_read = 1'b1;
    data_addr = a;
    step();
    idle();
  endtask

  function automatic logic [31:0] pick(input bit allow_oor);
    if (allow_oor && ($urandom % 8) == 0)
      return 32'h0001_0000 | $urandom;
    return 32'h400 + ($urandom % 16) * 4 + ($urandom % 4);
  endfunction

  task automatic rand_phase(input int n, input bit allow_oor);
    for (int k = 0; k < n; k++) begin
      instr_read = 1'($urandom);
      instr_addr = pick(allow_oor);
      data_read  = 1'($urandom);
      data_addr  = pick(allow_oor);
      data_write = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0;
      data_in    = $urandom;
      step();
    end
    idle();
  endtask

  initial begin
    rst        = 1'b0;
    instr_addr = '0;
    data_addr  = '0;
    data_in    = '0;
    idle();
    repeat (3) step();
    rst = 1'b1;

    // Basic write then read
    wr(32'h100, 32'hDEADBEEF, 4'hF);
    rd_data(32'h100);
    check("deadbeef", data_out, 32'hDEADBEEF);
    check("err_clean", {31'b0, access_err}, 32'h0);

    // Preload
    wr(32'h000, 32'h0000_0013, 4'hF);
    wr(32'h200, 32'h1122_3344, 4'hF);
    wr(32'h300, 32'h0000_0000, 4'hF);
    wr(32'h040, 32'h0000_0000, 4'hF);
    for (int k = 0; k < 16; k++) wr(32'h400 + 32'(k * 4), $urandom, 4'hF);

    // Byte strobes
    wr(32'h200, 32'hAABB_CCDD, 4'b0101);
    rd_data(32'h200);
    check("strobe", data_out, 32'h11BB_33DD);

    // Write-first on the data port
    idle();
    data_read  = 1'b1;
    data_addr  = 32'h300;
    data_in    = 32'h1234_5678;
    data_write = 4'b0011;
    step();
    idle();
    check("write_first", data_out, 32'h0000_5678);

    // Cross-port bypass
    data_addr  = 32'h040;
    data_in    = 32'hCAFE_F00D;
    data_write = 4'hF;
    instr_read = 1'b1;
    instr_addr = 32'h040;
    step();
    idle();
    check("bypass", instr_out, 32'hCAFE_F00D);

    rand_phase(150, 1'b0);
    check("err_after_rand", {31'b0, access_err}, 32'h0);

    // Out of range
    rd_data(32'h0001_0000);
    check("oor_read", data_out, 32'h0);
    check("oor_err", {31'b0, access_err}, 32'h1);
    wr(32'h0001_0000, 32'hFFFF_FFFF, 4'hF);
    rd_data(32'h0000_0000);
    check("oor_no_alias", data_out, 32'h0000_0013);

    rand_phase(150, 1'b1);
    check("err_sticky", {31'b0, access_err}, 32'h1);

    // Async reset in the middle of back-to-back reads
    instr_read = 1'b1;
    instr_addr = 32'h0;
    data_read  = 1'b1;
    data_addr  = 32'h100;
    step();
    step();
    check("burst_instr", instr_out, 32'h0000_0013);
    rst     = 1'b0;
    exp_i   = '0;
    exp_d   = '0;
    exp_err = 1'b0;
    #1;
    check("rst_instr", instr_out, 32'h0);
    check("rst_data", data_out, 32'h0);
    check("rst_err", {31'b0, access_err}, 32'h0);
    idle();
    data_addr  = 32'h100;
    data_in    = 32'h5555_5555;
    data_write = 4'hF;
    step();
    rst = 1'b1;
    rd_data(32'h100);
    check("rst_write_dropped", data_out, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
